agm_seq: RTL
============

# agm_seq

Sequencer that drives the enable side of the address generator block: fetches one 2048-byte row from external memory into the row-buffer BRAM through port A, then drains it as 512 32-bit words through port B under a valid/ready handshake. It sits between the top-level controller (start/done) and the address generator plus BRAM, and owns all enables, the BRAM write and read strobes, and the external-memory stall.

## Interface
- MEM_LAT, 1, external memory read latency in cycles (legal 1..4)
- NUM_ROWS, 128, rows per frame (2^18 / 2048)
- CLK  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a row (single-row mode) or a frame (auto-row mode); sampled only in IDLE
- mem_ready  in  1  external memory can accept a read this cycle
- out_ready  in  1  downstream accepts the word on the BRAM port B data bus
- e_mem_addr_en  out  1  advance external memory address (one byte read issued)
- stall  out  1  high in FETCH while mem_ready is low; freezes memory address
- w_bram_addr_en  out  1  advance port A address; equals e_mem_addr_en delayed MEM_LAT cycles
- WE_A  out  1  port A write enable; identical to w_bram_addr_en
- r_bram_addr_en  out  1  advance port B address; one word read issued
- EN_B  out  1  port B enable; identical to r_bram_addr_en
- out_valid  out  1  port B data bus holds an unconsumed word
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at end of row (single-row) or frame (auto-row)
- row_idx  out  clog2(NUM_ROWS)  index of row in progress

## Operation
- States: IDLE, FETCH, FLUSH, DRAIN, DONE. Reset: state IDLE, all outputs 0, all counters 0.
- IDLE: start=1 -> FETCH. start while busy ignored.
- FETCH: e_mem_addr_en = mem_ready; stall = !mem_ready. 12-bit fetch counter counts enables; after the 2048th enable -> FLUSH.
- Write pipeline: MEM_LAT-deep shift register of e_mem_addr_en feeds w_bram_addr_en/WE_A; runs in every state.
- FLUSH: exactly MEM_LAT cycles, no new fetches, pipeline empties; then DRAIN. mem_ready ignored.
- DRAIN: r_bram_addr_en = (issued < 512) && (!out_valid || out_ready). out_valid next = r_bram_addr_en ? 1 : (out_ready ? 0 : out_valid). Port B output register holds while EN_B=0. After the 512th accept (out_valid && out_ready) -> DONE.
- DONE: done=1 for one cycle, row_idx increments (wraps NUM_ROWS-1 -> 0); next state per Configuration.
- out_ready ignored when out_valid=0. Address counters are never reset by this block; port A/B counters wrap naturally at 2048/512 so every row aligns to BRAM address 0.
- rst mid-operation: immediate return to IDLE, pipeline and out_valid cleared; the address generator shares rst, so alignment is preserved.

## Timing
- start sampled cycle 0 -> first e_mem_addr_en cycle 1.
- First WE_A cycle 1+MEM_LAT; last WE_A = last fetch + MEM_LAT.
- Port B data valid the cycle after r_bram_addr_en (BRAM read latency 1).
- Unstalled row, MEM_LAT=1, out_ready=1: fetch cycles 1..2048, FLUSH 2049, r_bram_addr_en 2050..2561, out_valid 2051..2562, done at 2563.
- Each mem_ready=0 cycle in FETCH adds one cycle; each out_ready=0 cycle with out_valid=1 adds one cycle.

## Configuration
- AGM_SEQ_AUTOROW_EN defined: DONE -> FETCH directly while row_idx (before increment) < NUM_ROWS-1; done pulses only after the last row, then IDLE.
- Not defined: DONE -> IDLE after every row; done pulses per row; each row needs a new start.

## Structure
- package_fpga.v: ROW_BYTES=2048, ROW_WORDS=512, state encodings for IDLE/FETCH/FLUSH/DRAIN/DONE.
- One sub-module: agm_seq_dly, MEM_LAT-deep 1-bit shift register with synchronous clear on rst.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, busy=0; start during rst -> ignored.
- MEM_LAT=1, mem_ready=1, out_ready=1, start -> 2048 e_mem_addr_en, 2048 WE_A each one cycle later, 512 EN_B, done at cycle 2563, row_idx 0->1.
- mem_ready low cycles 100..109 -> stall=1 and e_mem_addr_en=0 in those cycles, done at 2573, total enables still 2048.
- out_ready toggling 1,0 during DRAIN -> out_valid stays high while unaccepted, EN_B never fires with out_valid=1 and out_ready=0, exactly 512 accepts.
- rst asserted at cycle 1000 in FETCH -> next cycle IDLE, all outputs 0; new start -> full normal row.
- AGM_SEQ_AUTOROW_EN, NUM_ROWS=2 -> two rows back-to-back with no IDLE between, single done after second row, row_idx 0->1->0.

Source files
------------

// File: rtl/agm_seq_pkg.sv
// Shared constants and state encoding for the row-fetch / row-drain sequencer.
// No logic of its own; sizes one BRAM row as 2048 bytes written, 512 words read.
// Imported by agm_seq and agm_seq_dly.
package agm_seq_pkg;

    // One row as seen from each BRAM port
    localparam int ROW_BYTES = 2048;
    localparam int ROW_WORDS = 512;

    // Counter widths: fetch counter counts 0..2047, word counters need to reach 512
    localparam int FETCH_W = 12;
    localparam int WORD_W  = 10;

    // Deepest supported external-memory read latency
    localparam int MAX_MEM_LAT = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/agm_seq_dly.sv
// Purpose: DEPTH-stage 1-bit delay line aligning BRAM port A writes with returning memory data.
// Latency: q follows d after exactly DEPTH clock cycles.
// Backpressure: none; shifts every cycle, synchronous clear on rst empties the line.
module agm_seq_dly
    import agm_seq_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    // Shift one stage per cycle; reset drops any in-flight write strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/agm_seq.sv
// Purpose: sequences one row fetch (2048 bytes into BRAM port A) then a 512-word drain from port B;
// Latency: first fetch 1 cycle after start, writes trail fetches by MEM_LAT, port B data 1 cycle after EN_B.
// Backpressure: mem_ready low stalls the fetch; out_ready low holds the port B word. Optional AGM_SEQ_AUTOROW_EN.
module agm_seq
    import agm_seq_pkg::*;
#(
    parameter  int MEM_LAT  = 1,
    parameter  int NUM_ROWS = 128,
    localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             start,
    input  logic             mem_ready,
    input  logic             out_ready,
    output logic             e_mem_addr_en,
    output logic             stall,
    output logic             w_bram_addr_en,
    output logic             WE_A,
    output logic             r_bram_addr_en,
    output logic             EN_B,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] row_idx
);

    localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(ROW_BYTES - 1);
    localparam logic [WORD_W-1:0]  WORDS_ALL  = WORD_W'(ROW_WORDS);
    localparam logic [WORD_W-1:0]  WORDS_LAST = WORD_W'(ROW_WORDS - 1);
    localparam logic [2:0]         FLUSH_LAST = 3'(MEM_LAT - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(NUM_ROWS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [FETCH_W-1:0] fetch_cnt;
    logic [2:0]         flush_cnt;
    logic [WORD_W-1:0]  rd_issued;
    logic [WORD_W-1:0]  rd_accepted;
    logic               accept;

    // A word leaves port B when it is on the bus and downstream takes it
    assign accept = out_valid && out_ready;

    // State register
    always_ff @(posedge CLK) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        state_nxt      = state;
        e_mem_addr_en  = 1'b0;
        stall          = 1'b0;
        r_bram_addr_en = 1'b0;
        done           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                e_mem_addr_en = mem_ready;
                stall         = !mem_ready;
                if (mem_ready && (fetch_cnt == FETCH_LAST)) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Let the last MEM_LAT reads land in BRAM before reading it back
                if (flush_cnt == FLUSH_LAST) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Only read a new word when the output register is free or being emptied
                r_bram_addr_en = (rd_issued < WORDS_ALL) && (!out_valid || out_ready);
                if (accept && (rd_accepted == WORDS_LAST)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef AGM_SEQ_AUTOROW_EN
                // Chain straight into the next row until the frame is complete
                if (row_idx != LAST_ROW) begin
                    state_nxt = ST_FETCH;
                end else begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end
`else
                state_nxt = ST_IDLE;
                done      = 1'b1;
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Per-state counters clear whenever their state is left, so each row starts from zero
    always_ff @(posedge CLK) begin
        if (rst) begin
            fetch_cnt   <= '0;
            flush_cnt   <= '0;
            rd_issued   <= '0;
            rd_accepted <= '0;
        end else begin
            fetch_cnt   <= (state == ST_FETCH) ? fetch_cnt + FETCH_W'(e_mem_addr_en) : '0;
            flush_cnt   <= (state == ST_FLUSH) ? flush_cnt + 3'd1 : '0;
            rd_issued   <= (state == ST_DRAIN) ? rd_issued + WORD_W'(r_bram_addr_en) : '0;
            rd_accepted <= (state == ST_DRAIN) ? rd_accepted + WORD_W'(accept) : '0;
        end
    end

    // Port B output register occupancy: set by a read, cleared by an accept, else held
    always_ff @(posedge CLK) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (r_bram_addr_en) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Row index advances once per completed row and wraps at the frame boundary
    always_ff @(posedge CLK) begin
        if (rst) begin
            row_idx <= '0;
        end else if (state == ST_DONE) begin
            row_idx <= (row_idx == LAST_ROW) ? '0 : row_idx + ROW_W'(1);
        end
    end

    // Port A write strobe trails the memory read strobe by the memory latency
    agm_seq_dly #(
        .DEPTH (MEM_LAT)
    ) u_dly (
        .clk (CLK),
        .rst (rst),
        .d   (e_mem_addr_en),
        .q   (w_bram_addr_en)
    );

    assign WE_A = w_bram_addr_en;
    assign EN_B = r_bram_addr_en;
    assign busy = (state != ST_IDLE);

endmodule
